// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU control path.
//   - 5-bit instruction opcodes and the ALU add code used for address/PC arithmetic
//   - instruction-register field positions
//   - control FSM state encoding (RESET, T0..T7, HALT)
//   - instruction class decode and the packed control word
package cpu_pkg;

  // Instruction opcodes (ir[31:27])
  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_ROR  = 5'b00111;
  localparam logic [4:0] OP_ROL  = 5'b01000;
  localparam logic [4:0] OP_SHR  = 5'b01001;
  localparam logic [4:0] OP_SHRA = 5'b01010;
  localparam logic [4:0] OP_SHL  = 5'b01011;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_ANDI = 5'b01101;
  localparam logic [4:0] OP_ORI  = 5'b01110;
  localparam logic [4:0] OP_DIV  = 5'b01111;
  localparam logic [4:0] OP_MUL  = 5'b10000;
  localparam logic [4:0] OP_NEG  = 5'b10001;
  localparam logic [4:0] OP_NOT  = 5'b10010;
  localparam logic [4:0] OP_MFHI = 5'b10111;
  localparam logic [4:0] OP_MFLO = 5'b11000;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  // ALU code driven during PC increment and effective-address steps
  localparam logic [4:0] ADD_OP_DEFAULT = OP_ADD;

  // Instruction-register field positions
  localparam int unsigned OPC_HI = 31;
  localparam int unsigned OPC_LO = 27;
  localparam int unsigned RA_HI  = 26;
  localparam int unsigned RA_LO  = 23;
  localparam int unsigned RB_HI  = 22;
  localparam int unsigned RB_LO  = 19;
  localparam int unsigned RC_HI  = 18;
  localparam int unsigned RC_LO  = 15;

  // Control FSM state encoding; T-steps equal their step number
  localparam int unsigned STATE_W = 4;
  localparam logic [STATE_W-1:0] ST_T0    = 4'd0;
  localparam logic [STATE_W-1:0] ST_T1    = 4'd1;
  localparam logic [STATE_W-1:0] ST_T2    = 4'd2;
  localparam logic [STATE_W-1:0] ST_T3    = 4'd3;
  localparam logic [STATE_W-1:0] ST_T4    = 4'd4;
  localparam logic [STATE_W-1:0] ST_T5    = 4'd5;
  localparam logic [STATE_W-1:0] ST_T6    = 4'd6;
  localparam logic [STATE_W-1:0] ST_T7    = 4'd7;
  localparam logic [STATE_W-1:0] ST_RESET = 4'd8;
  localparam logic [STATE_W-1:0] ST_HALT  = 4'd9;

  typedef enum logic [3:0] {
    ClsNop,
    ClsRtype,
    ClsImm,
    ClsMulDiv,
    ClsUnary,
    ClsMfhi,
    ClsMflo,
    ClsLd,
    ClsLdi,
    ClsSt,
    ClsHalt
  } op_class_e;

  // Groups opcodes that share one execute sequence
  function automatic op_class_e op_class(input logic [4:0] op);
    op_class_e cls;
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ROR,
      OP_ROL, OP_SHR, OP_SHRA, OP_SHL:         cls = ClsRtype;
      OP_ADDI, OP_ANDI, OP_ORI:                cls = ClsImm;
      OP_DIV, OP_MUL:                          cls = ClsMulDiv;
      OP_NEG, OP_NOT:                          cls = ClsUnary;
      OP_MFHI:                                 cls = ClsMfhi;
      OP_MFLO:                                 cls = ClsMflo;
      OP_LD:                                   cls = ClsLd;
      OP_LDI:                                  cls = ClsLdi;
      OP_ST:                                   cls = ClsSt;
      OP_HALT:                                 cls = ClsHalt;
      OP_NOP:                                  cls = ClsNop;
      default:                                 cls = ClsNop;
    endcase
    return cls;
  endfunction

  // One bit per datapath strobe plus the ALU operation
  typedef struct packed {
    logic       pc_out;
    logic       zhigh_out;
    logic       zlow_out;
    logic       mdr_out;
    logic       hi_out;
    logic       lo_out;
    logic       c_out;
    logic       ba_out;
    logic       r_out;
    logic       mar_in;
    logic       pc_in;
    logic       mdr_in;
    logic       ir_in;
    logic       y_in;
    logic       hi_in;
    logic       lo_in;
    logic       zhigh_in;
    logic       zlow_in;
    logic       r_in;
    logic       gra;
    logic       grb;
    logic       grc;
    logic       inc_pc;
    logic       read;
    logic       write;
    logic [4:0] alu_op;
  } ctrl_t;

  localparam int unsigned CTRL_W = $bits(ctrl_t);

endpackage

// File: rtl/control_step_decode.sv
// Combinational control-word decode for the control FSM.
//   state    in   current FSM state
//   op       in   instruction opcode ir[31:27]
//   ctrl     out  packed control word (strobes + ALU op)
//   last     out  this step retires the instruction (next is T0 entry)
//   wait_mem out  this step holds until mem_ready
//   to_halt  out  this step leaves for HALT
module control_step_decode
  import cpu_pkg::*;
#(
  parameter logic [4:0] ADD_OP = ADD_OP_DEFAULT
) (
  input  logic [STATE_W-1:0] state,
  input  logic [4:0]         op,
  output logic [CTRL_W-1:0]  ctrl,
  output logic               last,
  output logic               wait_mem,
  output logic               to_halt
);

  op_class_e cls;
  ctrl_t     cw;

  assign cls  = op_class(op);
  assign ctrl = cw;

  always_comb begin
    cw       = '0;
    last     = 1'b0;
    wait_mem = 1'b0;
    to_halt  = 1'b0;
    case (state)
      ST_T0: begin
        cw.pc_out  = 1'b1;
        cw.mar_in  = 1'b1;
        cw.inc_pc  = 1'b1;
        cw.zlow_in = 1'b1;
        cw.alu_op  = ADD_OP;
      end
      ST_T1: begin
        cw.zlow_out = 1'b1;
        cw.pc_in    = 1'b1;
        cw.read     = 1'b1;
        cw.mdr_in   = 1'b1;
        wait_mem    = 1'b1;
      end
      ST_T2: begin
        cw.mdr_out = 1'b1;
        cw.ir_in   = 1'b1;
      end
      ST_T3: begin
        case (cls)
          ClsRtype: begin
            cw.grc = 1'b1; cw.r_out = 1'b1; cw.y_in = 1'b1;
          end
          ClsImm: begin
            cw.grb = 1'b1; cw.r_out = 1'b1; cw.y_in = 1'b1;
          end
          ClsMulDiv: begin
            cw.gra = 1'b1; cw.r_out = 1'b1; cw.y_in = 1'b1;
          end
          ClsUnary: begin
            cw.grb = 1'b1; cw.r_out = 1'b1; cw.zlow_in = 1'b1;
            cw.alu_op = op;
          end
          ClsMfhi: begin
            cw.hi_out = 1'b1; cw.gra = 1'b1; cw.r_in = 1'b1;
            last = 1'b1;
          end
          ClsMflo: begin
            cw.lo_out = 1'b1; cw.gra = 1'b1; cw.r_in = 1'b1;
            last = 1'b1;
          end
          ClsLd, ClsLdi, ClsSt: begin
            cw.grb = 1'b1; cw.ba_out = 1'b1; cw.y_in = 1'b1;
          end
          ClsHalt: to_halt = 1'b1;
          default: last = 1'b1;
        endcase
      end
      ST_T4: begin
        case (cls)
          ClsRtype: begin
            cw.grb = 1'b1; cw.r_out = 1'b1; cw.zlow_in = 1'b1;
            cw.alu_op = op;
          end
          ClsImm: begin
            cw.c_out = 1'b1; cw.zlow_in = 1'b1;
            cw.alu_op = op;
          end
          ClsMulDiv: begin
            cw.grb = 1'b1; cw.r_out = 1'b1;
            cw.zhigh_in = 1'b1; cw.zlow_in = 1'b1;
            cw.alu_op = op;
          end
          ClsUnary: begin
            cw.zlow_out = 1'b1; cw.gra = 1'b1; cw.r_in = 1'b1;
            last = 1'b1;
          end
          ClsLd, ClsLdi, ClsSt: begin
            cw.c_out = 1'b1; cw.zlow_in = 1'b1;
            cw.alu_op = ADD_OP;
          end
          // Other classes never reach T4; retire rather than wander.
          default: last = 1'b1;
        endcase
      end
      ST_T5: begin
        case (cls)
          ClsRtype, ClsImm, ClsLdi: begin
            cw.zlow_out = 1'b1; cw.gra = 1'b1; cw.r_in = 1'b1;
            last = 1'b1;
          end
          ClsMulDiv: begin
            cw.zlow_out = 1'b1; cw.lo_in = 1'b1;
          end
          ClsLd, ClsSt: begin
            cw.zlow_out = 1'b1; cw.mar_in = 1'b1;
          end
          default: last = 1'b1;
        endcase
      end
      ST_T6: begin
        case (cls)
          ClsMulDiv: begin
            cw.zhigh_out = 1'b1; cw.hi_in = 1'b1;
            last = 1'b1;
          end
          ClsLd: begin
            cw.read = 1'b1; cw.mdr_in = 1'b1;
            wait_mem = 1'b1;
          end
          ClsSt: begin
            cw.gra = 1'b1; cw.r_out = 1'b1; cw.mdr_in = 1'b1;
          end
          default: last = 1'b1;
        endcase
      end
      ST_T7: begin
        case (cls)
          ClsLd: begin
            cw.mdr_out = 1'b1; cw.gra = 1'b1; cw.r_in = 1'b1;
            last = 1'b1;
          end
          ClsSt: begin
            cw.write = 1'b1;
            wait_mem = 1'b1;
            last = 1'b1;
          end
          default: last = 1'b1;
        endcase
      end
      // RESET, HALT and unused encodings drive nothing.
      default: cw = '0;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Hardwired control FSM: fetch (T0-T2) and per-opcode execute (T3-T7), one
// control step per clock, with memory wait states and halt handling.
//   clock, clear          clock and asynchronous active-low reset
//   ir                    instruction register (opcode in ir[31:27])
//   mem_ready             memory finished the pending Read/Write
//   stop                  halt request, taken at the next T0 entry
//   *out / *in / Gr* ...  datapath strobes
//   opcode                ALU operation
//   run, step             execution status and current T-step
module control_unit
  import cpu_pkg::*;
#(
  parameter logic [4:0] ADD_OP = ADD_OP_DEFAULT
) (
  input  logic        clock,
  input  logic        clear,
  input  logic [31:0] ir,
  input  logic        mem_ready,
  input  logic        stop,
  output logic        PCout,
  output logic        Zhighout,
  output logic        Zlowout,
  output logic        MDRout,
  output logic        HIout,
  output logic        LOout,
  output logic        Cout,
  output logic        BAout,
  output logic        Rout,
  output logic        MARin,
  output logic        PCin,
  output logic        MDRin,
  output logic        IRin,
  output logic        Yin,
  output logic        HIin,
  output logic        LOin,
  output logic        ZHighIn,
  output logic        ZLowIn,
  output logic        Rin,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        IncPC,
  output logic        Read,
  output logic        Write,
  output logic [4:0]  opcode,
  output logic        run,
  output logic [3:0]  step
);

  logic [STATE_W-1:0] state_q, state_d;
  logic [CTRL_W-1:0]  ctrl_vec;
  ctrl_t              cw;
  logic               last;
  logic               wait_mem;
  logic               to_halt;
  logic [STATE_W-1:0] t0_entry;

  // Register fields are consumed by the datapath, not here.
  logic unused_ir;
  assign unused_ir = ^{ir[RA_HI:RA_LO], ir[RB_HI:RB_LO], ir[RC_HI:RC_LO], ir[RC_LO-1:0]};

  control_step_decode #(
    .ADD_OP(ADD_OP)
  ) u_decode (
    .state   (state_q),
    .op      (ir[OPC_HI:OPC_LO]),
    .ctrl    (ctrl_vec),
    .last    (last),
    .wait_mem(wait_mem),
    .to_halt (to_halt)
  );

  // stop is only looked at on the edge that would enter T0.
  assign t0_entry = stop ? ST_HALT : ST_T0;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RESET: state_d = t0_entry;
      ST_HALT:  state_d = ST_HALT;
      ST_T0, ST_T1, ST_T2, ST_T3, ST_T4, ST_T5, ST_T6, ST_T7: begin
        if (wait_mem && !mem_ready) begin
          state_d = state_q;
        end else if (to_halt) begin
          state_d = ST_HALT;
        end else if (last) begin
          state_d = t0_entry;
        end else begin
          state_d = state_q + 4'd1;
        end
      end
      default: state_d = ST_RESET;
    endcase
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state_q <= ST_RESET;
    end else begin
      state_q <= state_d;
    end
  end

  assign cw = ctrl_t'(ctrl_vec);

  assign PCout    = cw.pc_out;
  assign Zhighout = cw.zhigh_out;
  assign Zlowout  = cw.zlow_out;
  assign MDRout   = cw.mdr_out;
  assign HIout    = cw.hi_out;
  assign LOout    = cw.lo_out;
  assign Cout     = cw.c_out;
  assign BAout    = cw.ba_out;
  assign Rout     = cw.r_out;
  assign MARin    = cw.mar_in;
  assign PCin     = cw.pc_in;
  assign MDRin    = cw.mdr_in;
  assign IRin     = cw.ir_in;
  assign Yin      = cw.y_in;
  assign HIin     = cw.hi_in;
  assign LOin     = cw.lo_in;
  assign ZHighIn  = cw.zhigh_in;
  assign ZLowIn   = cw.zlow_in;
  assign Rin      = cw.r_in;
  assign Gra      = cw.gra;
  assign Grb      = cw.grb;
  assign Grc      = cw.grc;
  assign IncPC    = cw.inc_pc;
  assign Read     = cw.read;
  assign Write    = cw.write;
  assign opcode   = cw.alu_op;

  assign run  = (state_q <= ST_T7);
  assign step = (state_q <= ST_T7) ? state_q : 4'd0;

endmodule

// File: tb/tb_control_unit.sv
module tb_control_unit;

  logic        clock;
  logic        clear;
  logic [31:0] ir;
  logic        mem_ready;
  logic        stop;
  logic PCout, Zhighout, Zlowout, MDRout, HIout, LOout, Cout, BAout, Rout;
  logic MARin, PCin, MDRin, IRin, Yin, HIin, LOin, ZHighIn, ZLowIn, Rin;
  logic Gra, Grb, Grc, IncPC, Read, Write;
  logic [4:0] opcode;
  logic       run;
  logic [3:0] cur_step;

  control_unit dut (
    .clock(clock), .clear(clear), .ir(ir), .mem_ready(mem_ready), .stop(stop),
    .PCout(PCout), .Zhighout(Zhighout), .Zlowout(Zlowout), .MDRout(MDRout),
    .HIout(HIout), .LOout(LOout), .Cout(Cout), .BAout(BAout), .Rout(Rout),
    .MARin(MARin), .PCin(PCin), .MDRin(MDRin), .IRin(IRin), .Yin(Yin),
    .HIin(HIin), .LOin(LOin), .ZHighIn(ZHighIn), .ZLowIn(ZLowIn), .Rin(Rin),
    .Gra(Gra), .Grb(Grb), .Grc(Grc), .IncPC(IncPC), .Read(Read), .Write(Write),
    .opcode(opcode), .run(run), .step(cur_step)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Strobe masks in the bench's own bit order
  localparam logic [24:0] M_PCOUT    = 25'd1 << 0;
  localparam logic [24:0] M_ZHIGHOUT = 25'd1 << 1;
  localparam logic [24:0] M_ZLOWOUT  = 25'd1 << 2;
  localparam logic [24:0] M_MDROUT   = 25'd1 << 3;
  localparam logic [24:0] M_HIOUT    = 25'd1 << 4;
  localparam logic [24:0] M_LOOUT    = 25'd1 << 5;
  localparam logic [24:0] M_COUT     = 25'd1 << 6;
  localparam logic [24:0] M_BAOUT    = 25'd1 << 7;
  localparam logic [24:0] M_ROUT     = 25'd1 << 8;
  localparam logic [24:0] M_MARIN    = 25'd1 << 9;
  localparam logic [24:0] M_PCIN     = 25'd1 << 10;
  localparam logic [24:0] M_MDRIN    = 25'd1 << 11;
  localparam logic [24:0] M_IRIN     = 25'd1 << 12;
  localparam logic [24:0] M_YIN      = 25'd1 << 13;
  localparam logic [24:0] M_HIIN     = 25'd1 << 14;
  localparam logic [24:0] M_LOIN     = 25'd1 << 15;
  localparam logic [24:0] M_ZHIGHIN  = 25'd1 << 16;
  localparam logic [24:0] M_ZLOWIN   = 25'd1 << 17;
  localparam logic [24:0] M_RIN      = 25'd1 << 18;
  localparam logic [24:0] M_GRA      = 25'd1 << 19;
  localparam logic [24:0] M_GRB      = 25'd1 << 20;
  localparam logic [24:0] M_GRC      = 25'd1 << 21;
  localparam logic [24:0] M_INCPC    = 25'd1 << 22;
  localparam logic [24:0] M_READ     = 25'd1 << 23;
  localparam logic [24:0] M_WRITE    = 25'd1 << 24;
  localparam logic [4:0]  ALU_ADD    = 5'b00011;

  logic [24:0] obs;
  assign obs = {Write, Read, IncPC, Grc, Grb, Gra, Rin, ZLowIn, ZHighIn, LOin, HIin, Yin,
                IRin, MDRin, PCin, MARin, Rout, BAout, Cout, LOout, HIout, MDRout,
                Zlowout, Zhighout, PCout};

  typedef struct packed {
    logic [3:0]  stp;
    logic [24:0] strb;
    logic [4:0]  alu;
    logic        mwait;
  } step_t;

  step_t seq[$];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_strobes"}, {7'd0, obs}, 32'd0);
    chk({tag, "_opcode"}, {27'd0, opcode}, 32'd0);
    chk({tag, "_run"}, {31'd0, run}, 32'd0);
    chk({tag, "_step"}, {28'd0, cur_step}, 32'd0);
  endtask

  task automatic push(input int s, input logic [24:0] m, input logic [4:0] a, input logic w);
    step_t r;
    r.stp = 4'(s); r.strb = m; r.alu = a; r.mwait = w;
    seq.push_back(r);
  endtask

  // Expected step list for one instruction, straight from the opcode table
  task automatic build_seq(input logic [4:0] op, output bit is_halt);
    seq.delete();
    is_halt = 1'b0;
    push(0, M_PCOUT | M_MARIN | M_INCPC | M_ZLOWIN, ALU_ADD, 1'b0);
    push(1, M_ZLOWOUT | M_PCIN | M_READ | M_MDRIN, 5'd0, 1'b1);
    push(2, M_MDROUT | M_IRIN, 5'd0, 1'b0);
    if (op inside {[5'd3:5'd11]}) begin
      push(3, M_GRC | M_ROUT | M_YIN, 5'd0, 1'b0);
      push(4, M_GRB | M_ROUT | M_ZLOWIN, op, 1'b0);
      push(5, M_ZLOWOUT | M_GRA | M_RIN, 5'd0, 1'b0);
    end else if (op inside {[5'd12:5'd14]}) begin
      push(3, M_GRB | M_ROUT | M_YIN, 5'd0, 1'b0);
      push(4, M_COUT | M_ZLOWIN, op, 1'b0);
      push(5, M_ZLOWOUT | M_GRA | M_RIN, 5'd0, 1'b0);
    end else if (op inside {5'd15, 5'd16}) begin
      push(3, M_GRA | M_ROUT | M_YIN, 5'd0, 1'b0);
      push(4, M_GRB | M_ROUT | M_ZHIGHIN | M_ZLOWIN, op, 1'b0);
      push(5, M_ZLOWOUT | M_LOIN, 5'd0, 1'b0);
      push(6, M_ZHIGHOUT | M_HIIN, 5'd0, 1'b0);
    end else if (op inside {5'd17, 5'd18}) begin
      push(3, M_GRB | M_ROUT | M_ZLOWIN, op, 1'b0);
      push(4, M_ZLOWOUT | M_GRA | M_RIN, 5'd0, 1'b0);
    end else if (op == 5'd23) begin
      push(3, M_HIOUT | M_GRA | M_RIN, 5'd0, 1'b0);
    end else if (op == 5'd24) begin
      push(3, M_LOOUT | M_GRA | M_RIN, 5'd0, 1'b0);
    end else if (op inside {5'd0, 5'd1, 5'd2}) begin
      push(3, M_GRB | M_BAOUT | M_YIN, 5'd0, 1'b0);
      push(4, M_COUT | M_ZLOWIN, ALU_ADD, 1'b0);
      if (op == 5'd1) begin
        push(5, M_ZLOWOUT | M_GRA | M_RIN, 5'd0, 1'b0);
      end else if (op == 5'd0) begin
        push(5, M_ZLOWOUT | M_MARIN, 5'd0, 1'b0);
        push(6, M_READ | M_MDRIN, 5'd0, 1'b1);
        push(7, M_MDROUT | M_GRA | M_RIN, 5'd0, 1'b0);
      end else begin
        push(5, M_ZLOWOUT | M_MARIN, 5'd0, 1'b0);
        push(6, M_GRA | M_ROUT | M_MDRIN, 5'd0, 1'b0);
        push(7, M_WRITE, 5'd0, 1'b1);
      end
    end else begin
      push(3, 25'd0, 5'd0, 1'b0);
      if (op == 5'd27) is_halt = 1'b1;
    end
  endtask

  // Starts at a falling edge with the DUT in T0; ends at the falling edge after
  // the instruction's last step. wait_n < 0 picks random memory latencies.
  task automatic exec_instr(input logic [31:0] irv, input int wait_n, input int stop_at,
                            output bit halted);
    bit          is_halt;
    bit          last_stop;
    int          w, irin_n, rin_n, exp_rin;
    step_t       r;
    string       tag;
    logic [4:0]  op;
    op = irv[31:27];
    build_seq(op, is_halt);
    ir = irv;
    irin_n = 0; rin_n = 0; exp_rin = 0; last_stop = 1'b0;
    for (int i = 0; i < seq.size(); i++) begin
      r = seq[i];
      w = r.mwait ? ((wait_n < 0) ? int'($urandom_range(0, 3)) : wait_n) : 0;
      if ((r.strb & M_RIN) != 0) exp_rin++;
      for (int k = 0; k <= w; k++) begin
        tag = $sformatf("op%05b_T%0d_c%0d", op, r.stp, k);
        chk({tag, "_step"}, {28'd0, cur_step}, {28'd0, r.stp});
        chk({tag, "_strobes"}, {7'd0, obs}, {7'd0, r.strb});
        chk({tag, "_opcode"}, {27'd0, opcode}, {27'd0, r.alu});
        chk({tag, "_run"}, {31'd0, run}, 32'd1);
        if (IRin) irin_n++;
        if (Rin) rin_n++;
        mem_ready = r.mwait ? (k == w) : 1'($urandom_range(0, 1));
        stop = (stop_at >= 0) && (i >= stop_at);
        last_stop = stop;
        @(negedge clock);
      end
    end
    chk($sformatf("op%05b_irin_pulses", op), irin_n, 1);
    chk($sformatf("op%05b_rin_cycles", op), rin_n, exp_rin);
    halted = is_halt || last_stop;
  endtask

  task automatic park_and_reset(input string tag);
    for (int k = 0; k < 3; k++) begin
      chk_idle($sformatf("%s_halt%0d", tag, k));
      mem_ready = 1'($urandom_range(0, 1));
      stop = 1'($urandom_range(0, 1));
      @(negedge clock);
    end
    clear = 1'b0;
    #1;
    chk_idle({tag, "_clr_async"});
    @(negedge clock);
    chk_idle({tag, "_clr_held"});
    clear = 1'b1;
    stop = 1'b0;
    @(negedge clock);
  endtask

  bit          halted;
  logic [31:0] rnd;
  int          stop_at;

  initial begin
    clear = 1'b0; ir = 32'd0; mem_ready = 1'b0; stop = 1'b0;
    repeat (2) @(negedge clock);
    chk_idle("reset");
    clear = 1'b1;
    @(negedge clock);

    // add interrupted by clear in T4
    ir = {5'b00011, 4'd1, 4'd2, 4'd3, 15'd0};
    mem_ready = 1'b1;
    repeat (4) @(negedge clock);
    chk("add_T4_step", {28'd0, cur_step}, 32'd4);
    chk("add_T4_strobes", {7'd0, obs}, {7'd0, M_GRB | M_ROUT | M_ZLOWIN});
    chk("add_T4_opcode", {27'd0, opcode}, 32'd3);
    #2 clear = 1'b0;
    #1 chk_idle("midclr_async");
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk_idle("midclr_held");
    clear = 1'b1;
    @(negedge clock);
    chk("release_step", {28'd0, cur_step}, 32'd0);
    chk("release_strobes", {7'd0, obs}, {7'd0, M_PCOUT | M_MARIN | M_INCPC | M_ZLOWIN});
    chk("release_opcode", {27'd0, opcode}, {27'd0, ALU_ADD});
    chk("release_run", {31'd0, run}, 32'd1);

    // shra R4,R3,R7, no memory wait
    exec_instr(32'h521B8000, 0, -1, halted);
    chk("shra_halted", {31'd0, halted}, 32'd0);
    // fetch stalled three cycles
    exec_instr({5'b00100, 27'h0123456}, 3, -1, halted);
    // mul
    exec_instr({5'b10000, 27'h1A00000}, 1, -1, halted);
    // st with two-cycle write wait
    exec_instr({5'b00010, 27'h0880000}, 2, -1, halted);
    // ld and ldi
    exec_instr({5'b00000, 27'h0400000}, 1, -1, halted);
    exec_instr({5'b00001, 27'h0400000}, 0, -1, halted);

    // stop raised in T4 of add: add retires, then HALT
    exec_instr({5'b00011, 27'h1234567}, 0, 4, halted);
    chk("stop_halted", {31'd0, halted}, 32'd1);
    park_and_reset("stop");

    // halt opcode
    exec_instr({5'b11011, 27'h0}, 0, -1, halted);
    park_and_reset("halt_op");

    // random instruction stream
    for (int n = 0; n < 80; n++) begin
      rnd = $urandom();
      stop_at = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 7)) : -1;
      exec_instr(rnd, -1, stop_at, halted);
      if (halted) begin
        park_and_reset($sformatf("rnd%0d", n));
      end else begin
        stop = 1'b0;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/control_unit.md
Name: control_unit

Overview:
- Hardwired control FSM that sequences the CPU datapath through fetch, decode and execute, one control step per clock.
- Consumes the instruction register and a memory-ready handshake.
- Drives every datapath strobe: register-file select/encode controls (Gra/Grb/Grc/Rin/Rout/BAout), bus-out, register-in, ALU opcode and memory Read/Write.
- Sits beside the datapath and replaces the per-instruction stimulus sequencing in the datapath benches.

Parameters:
- ADD_OP, 5'b00011, ALU opcode forced during effective-address and PC steps

Ports:
- clock  in  1  system clock; all state changes on rising edge
- clear  in  1  reset; asynchronous, active-low
- ir  in  32  instruction register (opcode=ir[31:27], Ra=ir[26:23], Rb=ir[22:19], Rc=ir[18:15])
- mem_ready  in  1  memory completed current Read/Write this cycle
- stop  in  1  request halt at next instruction boundary
- PCout, Zhighout, Zlowout, MDRout, HIout, LOout, Cout, BAout, Rout  out  1 each  bus drivers
- MARin, PCin, MDRin, IRin, Yin, HIin, LOin, ZHighIn, ZLowIn, Rin  out  1 each  register loads
- Gra, Grb, Grc  out  1 each  register-field select
- IncPC, Read, Write  out  1 each
- opcode  out  5  ALU operation
- run  out  1  high while executing; low in RESET/HALT
- step  out  4  current T-step, for debug

Behaviour:
- Moore outputs decoded from state plus ir[31:27]; no output is asserted unless listed for the step.
- clear low: state=RESET; all outputs 0; opcode=0; run=0; step=0. This applies immediately, including mid-instruction and during a memory wait.
- RESET -> T0 on first clock after clear high.
- Fetch:
  - T0: PCout, MARin, IncPC, ZLowIn, opcode=ADD_OP.
    - If stop=1 on entry edge, go to HALT instead.
  - T1: Zlowout, PCin, Read, MDRin.
    - Hold T1 with all strobes held while mem_ready=0; advance when mem_ready=1.
  - T2: MDRout, IRin.
- Execute from T3, by opcode:
- R-type add 00011, sub 00100, and 00101, or 00110, ror 00111, rol 01000, shr 01001, shra 01010, shl 01011:
  - T3 Grc,Rout,Yin
  - T4 Grb,Rout,ZLowIn, opcode=ir op
  - T5 Zlowout,Gra,Rin -> T0
- addi 01100, andi 01101, ori 01110:
  - T3 Grb,Rout,Yin
  - T4 Cout,ZLowIn, opcode=ir op
  - T5 Zlowout,Gra,Rin -> T0
- div 01111, mul 10000:
  - T3 Gra,Rout,Yin
  - T4 Grb,Rout,ZHighIn,ZLowIn, opcode=ir op
  - T5 Zlowout,LOin
  - T6 Zhighout,HIin -> T0
- neg 10001, not 10010:
  - T3 Grb,Rout,ZLowIn, opcode=ir op
  - T4 Zlowout,Gra,Rin -> T0
- mfhi 10111 / mflo 11000:
  - T3 HIout/LOout,Gra,Rin -> T0
- ld 00000, ldi 00001, st 00010 (effective address):
  - T3 Grb,BAout,Yin
  - T4 Cout,ZLowIn, opcode=ADD_OP
- ldi: T5 Zlowout,Gra,Rin -> T0.
- ld:
  - T5 Zlowout,MARin
  - T6 Read,MDRin; wait on mem_ready as in T1
  - T7 MDRout,Gra,Rin -> T0
- st:
  - T5 Zlowout,MARin
  - T6 Gra,Rout,MDRin
  - T7 Write; wait on mem_ready -> T0
- nop 11010 and all unlisted opcodes: T3 no strobes -> T0.
- halt 11011: -> HALT.
- HALT: all outputs 0, run=0; exit only via clear.
- mem_ready outside T1/T6(ld)/T7(st) is ignored. mem_ready already high on wait-state entry completes in one cycle.
- stop sampled only at T0 entry; stop asserted mid-instruction takes effect after the instruction retires.
- opcode=0 in every step not listed above.

Decomposition:
- Shared package cpu_pkg:
  - 5-bit opcode localparams (names as above)
  - state encoding (RESET, T0-T7, HALT)
  - instruction-field bit positions
- Sub-module control_step_decode: combinational (state, ir opcode) -> control word. The top holds the state register, wait handling and the stop/halt logic.

Test Plan:
- Reset: clear low for 2 clocks mid-T4 of an add -> all outputs 0, run=0; first clock after release enters T0, PCout=MARin=IncPC=1.
- shra R4,R3,R7 (ir=32'h521B8000), mem_ready=1 -> steps T0..T5 in 6 clocks:
  - T3 Grc,Rout,Yin
  - T4 Grb,Rout,ZLowIn, opcode=01010
  - T5 Zlowout,Gra,Rin
  - then T0.
- Fetch wait: mem_ready held 0 for 3 cycles in T1 -> T1 lasts 4 clocks with Read=MDRin=PCin=1 throughout; IRin pulses exactly once.
- mul (ir[31:27]=10000) -> T5 Zlowout,LOin; T6 Zhighout,HIin; ZHighIn and ZLowIn high together only in T4.
- st with write wait 2 cycles -> T7 Write high 3 clocks; Gra,Rout,MDRin in T6; no Rin asserted anywhere in the instruction.
- stop=1 during T4 of add -> add retires (T5 Rin), next edge enters HALT, run=0, outputs 0; halt opcode 11011 likewise parks in HALT until clear.
